// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing write access to a register bank via req/gnt handshake
module reg_write_arbiter #(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int NREG   = 6,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] wr_addr,
  input  logic [NREQ*WIDTH-1:0]  wr_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREG-1:0]        reg_wen,
  output logic [WIDTH-1:0]       reg_in,
  output logic                   busy,
  output logic                   addr_err
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, GRANT, WRITE, RELEASE} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_last, rr_n, pick, idx;
  logic found, legal, err_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [WIDTH-1:0] data_q, data_n, in_n;
  logic [NREQ-1:0] gnt_n;
  logic [NREG-1:0] wen_n;
  always_comb begin
    pick = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_last) + k) % NREQ);
      if (!found && req[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end
  assign legal = int'(addr_q) < NREG;
  always_comb begin
    state_n = state;
    rr_n = rr_last;
    gnt_n = gnt;
    wen_n = '0;
    in_n = reg_in;
    err_n = 1'b0;
    addr_n = addr_q;
    data_n = data_q;
    case (state)
      IDLE: if (found) begin
        state_n = GRANT;
        rr_n = pick;
        gnt_n = NREQ'(1) << pick;
        addr_n = wr_addr[int'(pick)*ADDR_W +: ADDR_W];
        data_n = wr_data[int'(pick)*WIDTH +: WIDTH];
      end
      GRANT: begin
        state_n = WRITE;
        wen_n = legal ? NREG'(1) << addr_q : '0;
        in_n = legal ? data_q : reg_in;
        err_n = !legal;
      end
      WRITE: state_n = RELEASE;
      RELEASE: if (!req[rr_last]) begin
        state_n = IDLE;
        gnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_last <= IW'(NREQ - 1);
      gnt <= '0;
      reg_wen <= '0;
      reg_in <= '0;
      busy <= 1'b0;
      addr_err <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state <= state_n;
      rr_last <= rr_n;
      gnt <= gnt_n;
      reg_wen <= wen_n;
      reg_in <= in_n;
      busy <= state_n != IDLE;
      addr_err <= err_n;
      addr_q <= addr_n;
      data_q <= data_n;
    end
  end
endmodule
